// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing on the master clock, stepped by the pix_en clock enable; sync/video decodes are combinational.
// Optional VGA_TEST_PATTERN_EN adds a registered colour-bar output (rgb) lagging the counters by one pixel.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [7:0] rgb
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = 10'd0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Compare in 11 bits so a sync/active boundary at 1024 cannot alias to 0.
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = !(({1'b0, hcount_q} >= HS_START) && ({1'b0, hcount_q} < HS_END));
  assign vsync       = !(({1'b0, vcount_q} >= VS_START) && ({1'b0, vcount_q} < VS_END));
  assign video_on    = ({1'b0, hcount_q} < H_ACT) && ({1'b0, vcount_q} < V_ACT);
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [2:0] bar_idx;
  logic [7:0] bar_col;
  logic [7:0] rgb_q, rgb_d;

  always_comb begin
    bar_idx = 3'(hcount_q / BAR_W);
    case (bar_idx)
      3'd0:    bar_col = 8'hFF;
      3'd1:    bar_col = 8'hFC;
      3'd2:    bar_col = 8'h1F;
      3'd3:    bar_col = 8'h1C;
      3'd4:    bar_col = 8'hE3;
      3'd5:    bar_col = 8'hE0;
      3'd6:    bar_col = 8'h03;
      default: bar_col = 8'h00;
    endcase
    rgb_d = rgb_q;
    if (pix_en) begin
      rgb_d = video_on ? bar_col : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= 8'h00;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule
